// File: rtl/dfe_apb_pkg.sv
// dfe_apb_pkg: register map, ID value, status width and FSM states for the DFE APB completer
package dfe_apb_pkg;
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_IRQ_EN = 8'h08;
  localparam logic [7:0] OFF_ID     = 8'h0C;
  localparam logic [7:0] OFF_COEF   = 8'h40;
  localparam logic [31:0] ID_VALUE  = 32'hDFE0_0001;
  localparam int STS_W = 8;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dfe_coef_bank.sv
// dfe_coef_bank: filter coefficient array with one APB write port, one APB read port and one datapath read port
module dfe_coef_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_COEF   = 16
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic                        we,
  input  logic [$clog2(NUM_COEF)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [$clog2(NUM_COEF)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]       rdata,
  input  logic [$clog2(NUM_COEF)-1:0] dp_raddr,
  output logic [DATA_WIDTH-1:0]       dp_rdata
);
  logic [DATA_WIDTH-1:0] mem [NUM_COEF];
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) for (int i = 0; i < NUM_COEF; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata    = mem[raddr];
  assign dp_rdata = mem[dp_raddr];
endmodule

// File: rtl/dfe_apb_completer.sv
// dfe_apb_completer: APB register completer for the DFE (CTRL, W1C STATUS, IRQ_EN, ID, COEF bank).
// Define DFE_APB_PSLVERR_EN to report erroneous transfers on PSLVERR.
module dfe_apb_completer
  import dfe_apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_COEF    = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [ADDR_WIDTH-1:0]       PADDR,
  input  logic [DATA_WIDTH-1:0]       PWDATA,
  output logic [DATA_WIDTH-1:0]       PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  input  logic [7:0]                  sts_set,
  input  logic [$clog2(NUM_COEF)-1:0] coef_raddr,
  output logic [DATA_WIDTH-1:0]       coef_rdata,
  output logic [DATA_WIDTH-1:0]       cfg_ctrl,
  output logic                        irq
);
  localparam int CW = $clog2(NUM_COEF);
  state_t                state;
  logic [3:0]            cnt;
  logic [7:0]            off;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wd_q, ctrl, coef_rd, rd_mux;
  logic [STS_W-1:0]      sts, irq_en;
  logic [5:0]            cix;
  logic                  coef_hit, err, we, unused;
  // upper address bits alias the 256-byte map
  assign unused   = ^PADDR;
  assign cix      = off[7:2] - OFF_COEF[7:2];
  assign coef_hit = off[7:6] != 2'b00 && int'(cix) < NUM_COEF;
  assign err      = off[1:0] != 2'b00 || (wr_q && off == OFF_ID) ||
                    !(off == OFF_CTRL || off == OFF_STATUS || off == OFF_IRQ_EN || off == OFF_ID || coef_hit);
  assign we       = state == RESP && PSEL && PENABLE && wr_q && !err;
  assign rd_mux   = off == OFF_CTRL   ? ctrl :
                    off == OFF_STATUS ? DATA_WIDTH'(sts) :
                    off == OFF_IRQ_EN ? DATA_WIDTH'(irq_en) :
                    off == OFF_ID     ? DATA_WIDTH'(ID_VALUE) : coef_rd;
  assign PREADY   = state == RESP;
  assign PRDATA   = state == RESP && !wr_q && !err ? rd_mux : '0;
  assign irq      = |(sts & irq_en);
  assign cfg_ctrl = ctrl;
`ifdef DFE_APB_PSLVERR_EN
  assign PSLVERR  = state == RESP && err;
`else
  assign PSLVERR  = 1'b0;
`endif
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state <= IDLE;
      cnt   <= '0;
      off   <= '0;
      wr_q  <= 1'b0;
      wd_q  <= '0;
    end else begin
      case (state)
        IDLE: if (PSEL && !PENABLE) begin
          off   <= PADDR[7:0];
          wr_q  <= PWRITE;
          wd_q  <= PWDATA;
          cnt   <= 4'(WAIT_CYCLES);
          state <= WAIT_CYCLES > 0 ? WAIT : RESP;
        end
        WAIT: if (!PSEL) state <= IDLE;
          else begin
            cnt   <= cnt - 4'd1;
            state <= cnt == 4'd1 ? RESP : WAIT;
          end
        default: state <= IDLE;
      endcase
    end
  // a set pulse in the same cycle as a W1C clear wins
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      ctrl   <= '0;
      sts    <= '0;
      irq_en <= '0;
    end else begin
      ctrl   <= we && off == OFF_CTRL ? wd_q : ctrl;
      irq_en <= we && off == OFF_IRQ_EN ? wd_q[STS_W-1:0] : irq_en;
      sts    <= (sts & ~(we && off == OFF_STATUS ? wd_q[STS_W-1:0] : '0)) | sts_set;
    end
  dfe_coef_bank #(.DATA_WIDTH(DATA_WIDTH), .NUM_COEF(NUM_COEF)) u_coef (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .we      (we && coef_hit),
    .waddr   (CW'(cix)),
    .wdata   (wd_q),
    .raddr   (CW'(cix)),
    .rdata   (coef_rd),
    .dp_raddr(coef_raddr),
    .dp_rdata(coef_rdata)
  );
endmodule

// File: tb/tb_dfe_apb_completer.sv
// tb_dfe_apb_completer: directed checks of the DFE APB completer with one and three wait states
module tb_dfe_apb_completer;
  logic clk = 0, rst_n = 0, rst3_n = 0, psel = 0, psel3 = 0, penable = 0, pwrite = 0;
  logic [31:0] paddr = 0, pwdata = 0;
  logic [7:0] sts_set = 0;
  logic [3:0] coef_raddr = 0;
  logic [31:0] prdata, prdata3, cfg_ctrl, cfg_ctrl3, coef_rdata, coef_rdata3;
  logic pready, pready3, pslverr, pslverr3, irq, irq3;
  int errs = 0, checks = 0;
`ifdef DFE_APB_PSLVERR_EN
  localparam logic EE = 1'b1;
`else
  localparam logic EE = 1'b0;
`endif

  always #5 clk = ~clk;

  dfe_apb_completer #(.WAIT_CYCLES(1)) dut (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .sts_set(sts_set), .coef_raddr(coef_raddr), .coef_rdata(coef_rdata), .cfg_ctrl(cfg_ctrl), .irq(irq)
  );
  dfe_apb_completer #(.WAIT_CYCLES(3)) dut3 (
    .PCLK(clk), .PRESETn(rst3_n), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3),
    .sts_set(8'h00), .coef_raddr(coef_raddr), .coef_rdata(coef_rdata3), .cfg_ctrl(cfg_ctrl3), .irq(irq3)
  );

  // One APB transfer starting 1ns after an edge; returns the cycle (setup = 1) in which PREADY was seen.
  task automatic apb(input bit d3, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [7:0] sts_in, output logic [31:0] rd, output logic er, output int n);
    pwrite = wr; paddr = a; pwdata = wd; penable = 0;
    if (d3) psel3 = 1; else psel = 1;
    @(posedge clk); #1 penable = 1; n = 2;
    while (!(d3 ? pready3 : pready) && n < 40) begin @(posedge clk); #1 n++; end
    rd = d3 ? prdata3 : prdata; er = d3 ? pslverr3 : pslverr; sts_set = sts_in;
    @(posedge clk); #1 psel = 0; psel3 = 0; penable = 0; sts_set = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; rst3_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pready !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0) begin errs++; $display("FAIL reset_bus: pready=%b prdata=%h pslverr=%b want 0", pready, prdata, pslverr); end
    rst_n = 1; rst3_n = 1;
    @(posedge clk); #1;
    checks++; if (cfg_ctrl !== 32'h0 || irq !== 1'b0) begin errs++; $display("FAIL reset_regs: cfg_ctrl=%h irq=%b want 0", cfg_ctrl, irq); end
    checks++; if (coef_rdata !== 32'h0 || pready3 !== 1'b0) begin errs++; $display("FAIL reset_coef: coef_rdata=%h pready3=%b want 0", coef_rdata, pready3); end
  endtask

  task automatic test_ctrl;
    logic [31:0] rd; logic er; int n;
    apb(0, 1, 32'h00, 32'hA5A5_0003, 0, rd, er, n);
    checks++; if (n !== 3) begin errs++; $display("FAIL ctrl_latency: pready cycle %0d want 3", n); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errs++; $display("FAIL ctrl_wresp: prdata=%h pslverr=%b want 0/0", rd, er); end
    checks++; if (cfg_ctrl !== 32'hA5A5_0003) begin errs++; $display("FAIL ctrl_cfg: got %h want a5a50003", cfg_ctrl); end
    apb(0, 0, 32'h00, 0, 0, rd, er, n);
    checks++; if (rd !== 32'hA5A5_0003) begin errs++; $display("FAIL ctrl_read: got %h want a5a50003", rd); end
  endtask

  task automatic test_coef;
    logic [31:0] rd; logic er; int n;
    apb(0, 1, 32'h48, 32'h1234, 0, rd, er, n);
    apb(0, 0, 32'h48, 0, 0, rd, er, n);
    checks++; if (rd !== 32'h0000_1234 || er !== 1'b0) begin errs++; $display("FAIL coef2_read: got %h/%b want 00001234/0", rd, er); end
    coef_raddr = 2; #1;
    checks++; if (coef_rdata !== 32'h1234) begin errs++; $display("FAIL coef2_dp: got %h want 00001234", coef_rdata); end
    apb(0, 1, 32'h7C, 32'hCAFE, 0, rd, er, n);
    coef_raddr = 15; #1;
    checks++; if (coef_rdata !== 32'hCAFE) begin errs++; $display("FAIL coef15_dp: got %h want 0000cafe", coef_rdata); end
    coef_raddr = 0; #1;
    checks++; if (coef_rdata !== 32'h0) begin errs++; $display("FAIL coef0_dp: got %h want 0", coef_rdata); end
  endtask

  task automatic test_id;
    logic [31:0] rd; logic er; int n;
    apb(0, 0, 32'h0C, 0, 0, rd, er, n);
    checks++; if (rd !== 32'hDFE0_0001 || er !== 1'b0) begin errs++; $display("FAIL id_read: got %h/%b want dfe00001/0", rd, er); end
    apb(0, 1, 32'h0C, 32'h0, 0, rd, er, n);
    checks++; if (er !== EE) begin errs++; $display("FAIL id_write_err: pslverr=%b want %b", er, EE); end
    apb(0, 0, 32'h0C, 0, 0, rd, er, n);
    checks++; if (rd !== 32'hDFE0_0001) begin errs++; $display("FAIL id_reread: got %h want dfe00001", rd); end
  endtask

  task automatic test_status_irq;
    logic [31:0] rd; logic er; int n;
    apb(0, 1, 32'h08, 32'hFFFF_FF04, 0, rd, er, n);
    apb(0, 0, 32'h08, 0, 0, rd, er, n);
    checks++; if (rd !== 32'h04) begin errs++; $display("FAIL irqen_read: got %h want 00000004", rd); end
    sts_set = 8'h01; @(posedge clk); #1 sts_set = 0;
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL irq_masked: irq=%b want 0", irq); end
    sts_set = 8'h04; @(posedge clk); #1 sts_set = 0;
    checks++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_set: irq=%b want 1", irq); end
    apb(0, 0, 32'h04, 0, 0, rd, er, n);
    checks++; if (rd !== 32'h05) begin errs++; $display("FAIL status_sticky: got %h want 00000005", rd); end
    apb(0, 1, 32'h04, 32'h04, 8'h04, rd, er, n);
    apb(0, 0, 32'h04, 0, 0, rd, er, n);
    checks++; if (rd !== 32'h05 || irq !== 1'b1) begin errs++; $display("FAIL status_set_wins: got %h irq=%b want 00000005/1", rd, irq); end
    apb(0, 1, 32'h04, 32'h04, 0, rd, er, n);
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL irq_clear: irq=%b want 0", irq); end
    apb(0, 0, 32'h04, 0, 0, rd, er, n);
    checks++; if (rd !== 32'h01) begin errs++; $display("FAIL status_w1c: got %h want 00000001", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int n;
    apb(0, 0, 32'h02, 0, 0, rd, er, n);
    checks++; if (rd !== 32'h0 || er !== EE) begin errs++; $display("FAIL err_misaligned: got %h/%b want 0/%b", rd, er, EE); end
    apb(0, 0, 32'h20, 0, 0, rd, er, n);
    checks++; if (rd !== 32'h0 || er !== EE) begin errs++; $display("FAIL err_unmapped: got %h/%b want 0/%b", rd, er, EE); end
    apb(0, 0, 32'h80, 0, 0, rd, er, n);
    checks++; if (rd !== 32'h0 || er !== EE) begin errs++; $display("FAIL err_coef_range: got %h/%b want 0/%b", rd, er, EE); end
    apb(0, 1, 32'h42, 32'hFFFF, 0, rd, er, n);
    apb(0, 1, 32'h01, 32'h0, 0, rd, er, n);
    checks++; if (er !== EE || cfg_ctrl !== 32'hA5A5_0003) begin errs++; $display("FAIL err_write_drop: pslverr=%b cfg_ctrl=%h want %b/a5a50003", er, cfg_ctrl, EE); end
    apb(0, 0, 32'h40, 0, 0, rd, er, n);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errs++; $display("FAIL err_coef0_kept: got %h/%b want 0/0", rd, er); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er; int n;
    apb(0, 1, 32'h00, 32'h11, 0, rd, er, n);
    apb(0, 0, 32'h00, 0, 0, rd, er, n);
    checks++; if (rd !== 32'h11 || n !== 3) begin errs++; $display("FAIL b2b_ctrl: got %h cycle %0d want 00000011 cycle 3", rd, n); end
    apb(0, 1, 32'h44, 32'h99, 0, rd, er, n);
    apb(0, 0, 32'h44, 0, 0, rd, er, n);
    checks++; if (rd !== 32'h99 || n !== 3) begin errs++; $display("FAIL b2b_coef: got %h cycle %0d want 00000099 cycle 3", rd, n); end
  endtask

  task automatic test_abort;
    logic [31:0] rd; logic er; int n; bit seen;
    seen = 0;
    pwrite = 1; paddr = 32'h00; pwdata = 32'h77; penable = 0; psel3 = 1;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 psel3 = 0; penable = 0;
    repeat (4) begin @(posedge clk); #1 if (pready3) seen = 1; end
    checks++; if (seen || cfg_ctrl3 !== 32'h0) begin errs++; $display("FAIL abort: pready_seen=%b cfg_ctrl3=%h want 0/0", seen, cfg_ctrl3); end
    apb(1, 0, 32'h00, 0, 0, rd, er, n);
    checks++; if (rd !== 32'h0 || n !== 5) begin errs++; $display("FAIL abort_read: got %h cycle %0d want 0 cycle 5", rd, n); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int n; bit seen;
    seen = 0;
    apb(1, 1, 32'h40, 32'h55, 0, rd, er, n);
    apb(1, 0, 32'h40, 0, 0, rd, er, n);
    checks++; if (rd !== 32'h55 || n !== 5) begin errs++; $display("FAIL w3_coef0: got %h cycle %0d want 00000055 cycle 5", rd, n); end
    pwrite = 1; paddr = 32'h40; pwdata = 32'hBEEF; penable = 0; psel3 = 1;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 rst3_n = 0;
    #2 rst3_n = 1; psel3 = 0; penable = 0;
    repeat (4) begin @(posedge clk); #1 if (pready3) seen = 1; end
    coef_raddr = 0; #1;
    checks++; if (seen || coef_rdata3 !== 32'h0) begin errs++; $display("FAIL midreset: pready_seen=%b coef0=%h want 0/0", seen, coef_rdata3); end
    apb(1, 0, 32'h40, 0, 0, rd, er, n);
    checks++; if (rd !== 32'h0 || n !== 5) begin errs++; $display("FAIL midreset_read: got %h cycle %0d want 0 cycle 5", rd, n); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_ctrl;
    test_coef;
    test_id;
    test_status_irq;
    test_errors;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
